store_buffer: RTL and testbench

Four-entry store buffer between the MEM-stage pipeline register and `data_mem`. It lets stores retire without waiting for the two-cycle `data_mem` write sequence and drains them in program order when the memory port is free. Loads pass straight to `data_mem` when no buffered store touches their word. A full-word load that hits a buffered full-word store is forwarded; any other overlap stalls until the buffer drains.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/sb_match.sv | 32 +++
 rtl/store_buffer.sv | 138 +++++++++++++
 tb/tb_store_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory path: sign_mask fields, LED address,
// drain FSM encodings and the store buffer entry layout.
package dmem_pkg;

    localparam int SM_SIGN = 3;
    localparam int SM_WORD = 2;
    localparam int SM_HALF = 1;
    localparam int SM_BYTE = 0;

    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sign_mask;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// DEPTH-way word-address comparator; reports the youngest valid entry whose
// word address equals the query, searching backwards from tail-1 with wrap.
module sb_match #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0][29:0]      entry_word,
    input  logic [DEPTH-1:0]            entry_valid,
    input  logic [$clog2(DEPTH)-1:0]    tail,
    input  logic [29:0]                 query_word,
    output logic                        any_match,
    output logic [$clog2(DEPTH)-1:0]    match_idx
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Offset i=0 is the youngest entry; the first hit found wins.
    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail - PTR_W'(i + 1);
            if (!any_match && entry_valid[idx] && entry_word[idx] == query_word) begin
                any_match = 1'b1;
                match_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Four-entry in-order store buffer in front of data_mem: retires stores early,
// drains them through a three-state FSM and forwards full-word load hits.
module store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t              entries [DEPTH];
    sb_entry_t              head_entry;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [PTR_W:0]         count;
    drain_state_t           state;
    drain_state_t           state_next;
    logic                   fwd_sel;
    logic [31:0]            fwd_data;

    logic [DEPTH-1:0][29:0] entry_word;
    logic [DEPTH-1:0]       entry_valid;
    logic                   any_match;
    logic [PTR_W-1:0]       match_idx;

    logic store_req, load_req, full, fwd_hit, pass_load, push, pop;

    always_comb begin
        entry_word  = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_word[i]  = entries[i].addr[31:2];
            entry_valid[i] = {1'b0, PTR_W'(i) - head} < count;
        end
    end

    sb_match #(.DEPTH(DEPTH)) u_match (
        .entry_word  (entry_word),
        .entry_valid (entry_valid),
        .tail        (tail),
        .query_word  (cpu_addr[31:2]),
        .any_match   (any_match),
        .match_idx   (match_idx)
    );

    // A store always beats a simultaneous load; loads own the port only while
    // the drain FSM is idle, which keeps mem_read_data off the stall path.
    always_comb begin
        head_entry = entries[head];
        store_req  = cpu_memwrite;
        load_req   = cpu_memread && !cpu_memwrite;
        full       = (count == (PTR_W + 1)'(DEPTH));
        fwd_hit    = load_req && any_match &&
                     entries[match_idx].sign_mask[SM_WORD] && cpu_sign_mask[SM_WORD];
        pass_load  = load_req && !any_match && (state == IDLE);
        push       = store_req && !full;
        pop        = (state == HOLD) && mem_clk_stall;
        cpu_stall  = (store_req && full) ||
                     (load_req && any_match && !fwd_hit) ||
                     (load_req && !any_match && (state != IDLE));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr: cpu_addr, data: cpu_write_data, sign_mask: cpu_sign_mask};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= IDLE;
            fwd_sel  <= 1'b0;
            fwd_data <= '0;
        end else begin
            state   <= state_next;
            fwd_sel <= fwd_hit;
            if (fwd_hit) fwd_data <= entries[match_idx].data;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A store landing in an empty buffer is issued on the very next cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if ((count != '0 || push) && !pass_load) state_next = ISSUE;
            ISSUE:   state_next = HOLD;
            HOLD:    if (mem_clk_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_sign_mask  = '0;
        mem_memwrite   = 1'b0;
        mem_memread    = 1'b0;
        if (state == ISSUE || state == HOLD) begin
            mem_addr       = head_entry.addr;
            mem_write_data = head_entry.data;
            mem_sign_mask  = head_entry.sign_mask;
            mem_memwrite   = (state == ISSUE);
        end else if (pass_load) begin
            mem_addr      = cpu_addr;
            mem_sign_mask = cpu_sign_mask;
            mem_memread   = 1'b1;
        end
        cpu_read_data = fwd_sel ? fwd_data : mem_read_data;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against an architectural
// memory model plus a behavioural data_mem with a two-cycle write.
module tb_store_buffer;
    import dmem_pkg::*;

    localparam int DEPTH       = 4;
    localparam int STALL_LIMIT = 60;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [3:0]  cpu_sign_mask;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } store_t;

    // Index 0 is the program-order (architectural) image, index 1 is data_mem.
    logic [7:0] mems [2][16384];
    store_t     pendingQ [$];
    logic       ackEn;
    logic       holdPending;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_memwrite   (cpu_memwrite),
        .cpu_memread    (cpu_memread),
        .cpu_sign_mask  (cpu_sign_mask),
        .cpu_read_data  (cpu_read_data),
        .cpu_stall      (cpu_stall),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_sign_mask  (mem_sign_mask),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] readMem(input int which, input logic [31:0] addr, input logic [3:0] mask);
        logic [13:0] a;
        logic [31:0] r;
        a = addr[13:0];
        if (mask[SM_WORD]) begin
            a[1:0] = 2'b00;
            r = {mems[which][a+3], mems[which][a+2], mems[which][a+1], mems[which][a]};
        end else if (mask[SM_HALF]) begin
            a[0] = 1'b0;
            r = {16'h0, mems[which][a+1], mems[which][a]};
            if (mask[SM_SIGN]) r[31:16] = {16{r[15]}};
        end else begin
            r = {24'h0, mems[which][a]};
            if (mask[SM_SIGN]) r[31:8] = {24{r[7]}};
        end
        return r;
    endfunction

    task automatic storeMem(input int which, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        logic [13:0] a;
        a = addr[13:0];
        if (mask[SM_WORD]) begin
            a[1:0] = 2'b00;
            for (int k = 0; k < 4; k++) mems[which][a+k] = data[8*k +: 8];
        end else if (mask[SM_HALF]) begin
            a[0] = 1'b0;
            mems[which][a]   = data[7:0];
            mems[which][a+1] = data[15:8];
        end else begin
            mems[which][a] = data[7:0];
        end
    endtask

    // data_mem: synchronous read, write accepted on memwrite and completed on
    // the following edge while mem_clk_stall is high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_clk_stall <= 1'b0;
            mem_read_data <= '0;
            holdPending = 1'b0;
        end else begin
            if (mem_memread) mem_read_data <= readMem(1, mem_addr, mem_sign_mask);
            if (mem_memwrite) begin
                holdPending = 1'b1;
                if (pendingQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'(mem_memwrite), 32'd0);
                end else begin
                    checkOutput("drain_addr", mem_addr, pendingQ[0].addr);
                    checkOutput("drain_data", mem_write_data, pendingQ[0].data);
                    checkOutput("drain_mask", 32'(mem_sign_mask), 32'(pendingQ[0].mask));
                end
            end
            if (mem_clk_stall) begin
                storeMem(1, mem_addr, mem_write_data, mem_sign_mask);
                if (pendingQ.size() != 0) void'(pendingQ.pop_front());
                mem_clk_stall <= 1'b0;
                holdPending = 1'b0;
            end else if (holdPending && ackEn) begin
                mem_clk_stall <= 1'b1;
            end
        end
    end

    // Stall expectation from the pending-store list alone: full for stores,
    // youngest word overlap for loads; a non-overlapping load is left open.
    task automatic predictStall(input logic wr, input logic rd, input logic [31:0] addr,
                                input logic [3:0] mask, output logic known, output logic exp,
                                output logic isFwd);
        known = 1'b0;
        exp   = 1'b0;
        isFwd = 1'b0;
        if (wr) begin
            known = 1'b1;
            exp   = (pendingQ.size() == DEPTH);
        end else if (rd) begin
            for (int i = pendingQ.size() - 1; i >= 0; i--) begin
                if (!known && pendingQ[i].addr[31:2] == addr[31:2]) begin
                    known = 1'b1;
                    isFwd = pendingQ[i].mask[SM_WORD] && mask[SM_WORD];
                    exp   = !isFwd;
                end
            end
        end
    endtask

    // Called at a falling edge; holds the request until it is accepted, then
    // returns at the next falling edge with inputs cleared.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] mask);
        int          waited;
        logic        known, expStall, isFwd, timedOut;
        logic [31:0] expRead;
        cpu_memwrite   = wr;
        cpu_memread    = rd;
        cpu_addr       = addr;
        cpu_write_data = wdata;
        cpu_sign_mask  = mask;
        waited   = 0;
        timedOut = 1'b0;
        forever begin
            #4;
            predictStall(wr, rd, addr, mask, known, expStall, isFwd);
            if (known) checkOutput("stall", 32'(cpu_stall), 32'(expStall));
            if (!cpu_stall) break;
            if (waited == STALL_LIMIT) begin
                checkOutput("stall_timeout", 32'(cpu_stall), 32'd0);
                timedOut = 1'b1;
                break;
            end
            @(negedge clk);
            waited++;
        end
        if (!timedOut) begin
            if (rd && !wr) begin
                if (isFwd) checkOutput("fwd_no_memread", 32'(mem_memread), 32'd0);
                if (!known) begin
                    checkOutput("pass_memread", 32'(mem_memread), 32'd1);
                    checkOutput("pass_addr", mem_addr, addr);
                end
            end
            expRead = readMem(0, addr, mask);
            @(posedge clk);
            if (wr) begin
                storeMem(0, addr, wdata, mask);
                pendingQ.push_back('{addr: addr, data: wdata, mask: mask});
            end
            @(negedge clk);
            if (rd && !wr) checkOutput("load_data", cpu_read_data, expRead);
        end else begin
            @(negedge clk);
        end
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b0;
    endtask

    task automatic drainAll();
        int n = 0;
        while (pendingQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_done", 32'(pendingQ.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] countBefore;
        int          r;
        int          kind;

        for (int i = 0; i < 16384; i++) begin
            mems[0][i] = 8'h00;
            mems[1][i] = 8'h00;
        end
        ackEn          = 1'b1;
        rst_n          = 1'b0;
        cpu_addr       = '0;
        cpu_write_data = '0;
        cpu_memwrite   = 1'b0;
        cpu_memread    = 1'b0;
        cpu_sign_mask  = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wr", 32'(mem_memwrite), 32'd0);
        checkOutput("rst_mem_rd", 32'(mem_memread), 32'd0);
        checkOutput("rst_read_data", cpu_read_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Store issued next cycle for one cycle; a second store lands in the pop cycle.
        applyStimulus(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'b0100);
        checkOutput("issue_addr", mem_addr, 32'h100);
        checkOutput("issue_wr", 32'(mem_memwrite), 32'd1);
        @(negedge clk);
        checkOutput("hold_wr", 32'(mem_memwrite), 32'd0);
        checkOutput("hold_addr", mem_addr, 32'h100);
        countBefore = 32'(dut.count);
        checkOutput("count_before_pop", countBefore, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h104, 32'h0BAD_F00D, 4'b0100);
        checkOutput("count_same", 32'(dut.count), 32'd1);
        drainAll();

        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0000_1234, 4'b0100);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 4'b0100);
        checkOutput("fwd_value", cpu_read_data, 32'h0000_1234);
        drainAll();

        applyStimulus(1'b1, 1'b0, 32'h41, 32'h0000_00AB, 4'b0001);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 4'b0100);
        checkOutput("overlap_value", cpu_read_data, 32'h0000_AB34);
        drainAll();

        // Fill to full with data_mem never completing the write.
        ackEn = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 1'b0, 32'h80 + 32'(4 * i), 32'h1000 + 32'(i), 4'b0100);
        cpu_memwrite = 1'b1; cpu_addr = 32'h90; cpu_write_data = 32'h2000; cpu_sign_mask = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #4;
            checkOutput("full_stall", 32'(cpu_stall), 32'd1);
            @(negedge clk);
        end
        ackEn = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h90, 32'h2000, 4'b0100);
        drainAll();

        applyStimulus(1'b1, 1'b0, LED_ADDR, 32'h0000_0005, 4'b0100);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b0, 32'h200 + 32'(4 * i), $urandom, 4'b0100);
        drainAll();
        checkOutput("led_written", readMem(1, LED_ADDR, 4'b0100), 32'h5);

        // Reset while a write sits in HOLD.
        ackEn = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h5555_5555, 4'b0100);
        @(negedge clk);
        checkOutput("in_hold", 32'(dut.state), 32'(HOLD));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_count", 32'(dut.count), 32'd0);
        checkOutput("mid_rst_state", 32'(dut.state), 32'(IDLE));
        checkOutput("mid_rst_stall", 32'(cpu_stall), 32'd0);
        checkOutput("mid_rst_addr", mem_addr, 32'd0);
        checkOutput("mid_rst_wdata", mem_write_data, 32'd0);
        checkOutput("mid_rst_mask", 32'(mem_sign_mask), 32'd0);
        checkOutput("mid_rst_wr", 32'(mem_memwrite), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pendingQ.delete();
        for (int i = 0; i < 16384; i++) mems[0][i] = mems[1][i];
        ackEn = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            r    = $urandom_range(0, 9);
            kind = $urandom_range(0, 4);
            a    = 32'h40 + 32'($urandom_range(0, 31));
            if (r < 4) begin
                case (kind)
                    0, 1:    applyStimulus(1'b1, 1'b0, a & ~32'h3, $urandom, 4'b0100);
                    2:       applyStimulus(1'b1, 1'b0, a & ~32'h1, $urandom, 4'b0010);
                    default: applyStimulus(1'b1, 1'b0, a, $urandom, 4'b0001);
                endcase
            end else if (r < 8) begin
                case (kind)
                    0, 1:    applyStimulus(1'b0, 1'b1, a & ~32'h3, 32'h0, 4'b0100);
                    2:       applyStimulus(1'b0, 1'b1, a & ~32'h1, 32'h0, 4'b1010);
                    3:       applyStimulus(1'b0, 1'b1, a, 32'h0, 4'b1001);
                    default: applyStimulus(1'b0, 1'b1, a, 32'h0, 4'b0001);
                endcase
            end else begin
                @(negedge clk);
            end
        end
        drainAll();

        for (int w = 32'h40; w < 32'h60; w += 4)
            checkOutput("final_word", readMem(1, 32'(w), 4'b0100), readMem(0, 32'(w), 4'b0100));
        for (int w = 32'h200; w < 32'h228; w += 4)
            checkOutput("wrap_word", readMem(1, 32'(w), 4'b0100), readMem(0, 32'(w), 4'b0100));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
